// File: rtl/iob_cpu_bus_router_pkg.sv
// iob_cpu_bus_router_pkg: request/response bus widths, field offsets and router FSM state encodings
package iob_cpu_bus_router_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction
  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction
  function automatic int req_wstrb_lo();
    return 0;
  endfunction
  function automatic int req_wdata_lo(input int dw);
    return dw / 8;
  endfunction
  function automatic int req_addr_lo(input int dw);
    return dw + dw / 8;
  endfunction
  function automatic int req_valid_bit(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction
  function automatic int resp_ready_bit();
    return 0;
  endfunction
  function automatic int resp_rdata_lo();
    return 1;
  endfunction
endpackage

// File: rtl/iob_cpu_bus_router_demux.sv
// iob_bus_demux: drives the latched request onto the selected s_req slice and muxes that slave's response back
module iob_bus_demux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_W = 2,
  parameter int REQ_W = 69,
  parameter int RESP_W = 33
) (
  input  logic                       active,
  input  logic [SEL_W-1:0]           sel,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  output logic [N_SLAVES*REQ_W-1:0]  s_req,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp,
  output logic [DATA_W-1:0]          rdata,
  output logic                       ready
);
  always_comb begin
    s_req = '0;
    rdata = '0;
    ready = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (32'(sel) == i) begin
        s_req[i*REQ_W +: REQ_W] = active ? {1'b1, addr, wdata, wstrb} : '0;
        rdata = s_resp[i*RESP_W+1 +: DATA_W];
        ready = s_resp[i*RESP_W];
      end
    end
  end
endmodule

// File: rtl/iob_cpu_bus_router.sv
// iob_cpu_bus_router: registered CPU-to-N-slave router with boot remap, per-request timeout and error response
module iob_cpu_bus_router
  import iob_cpu_bus_router_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_W = 2,
  parameter int BOOT_SLAVE = 0,
  parameter int TIMEOUT_W = 8,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF,
  localparam int REQ_W = req_w(ADDR_W, DATA_W),
  localparam int RESP_W = resp_w(DATA_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       boot,
  input  logic                       cpu_valid,
  input  logic                       cpu_instr,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic [DATA_W/8-1:0]        cpu_wstrb,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_ready,
  output logic                       cpu_err,
  output logic                       err_sticky,
  output logic [N_SLAVES*REQ_W-1:0]  s_req,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp
);
  localparam int NSEL = 2**SEL_W;
  localparam logic [NSEL-1:0] MAPPED = NSEL'((64'd1 << N_SLAVES) - 64'd1);
  logic [1:0] state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic unmap_q, unmap_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic ready_q, ready_d;
  logic err_q, err_d;
  logic sticky_q, sticky_d;
  logic [SEL_W-1:0] sel_in;
  logic timeout, fail, active, s_ready;
  logic [DATA_W-1:0] s_rdata;
  assign sel_in = boot && cpu_instr ? SEL_W'(BOOT_SLAVE) : cpu_addr[ADDR_W-1 -: SEL_W];
  assign timeout = &cnt_q;
  assign fail = unmap_q || timeout;
  assign active = state_q == WAIT && !fail;
  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_err = err_q;
  assign err_sticky = sticky_q;
  iob_bus_demux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .N_SLAVES(N_SLAVES),
    .SEL_W(SEL_W),
    .REQ_W(REQ_W),
    .RESP_W(RESP_W)
  ) u_demux (
    .active(active),
    .sel(sel_q),
    .addr(addr_q),
    .wdata(wdata_q),
    .wstrb(wstrb_q),
    .s_req(s_req),
    .s_resp(s_resp),
    .rdata(s_rdata),
    .ready(s_ready)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    sel_d = sel_q;
    unmap_d = unmap_q;
    cnt_d = '0;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d = 1'b0;
    sticky_d = sticky_q;
    if (state_q == IDLE && cpu_valid) begin
      state_d = WAIT;
      addr_d = cpu_addr;
      wdata_d = cpu_wdata;
      wstrb_d = cpu_wstrb;
      sel_d = sel_in;
      unmap_d = !MAPPED[sel_in];
    end
    if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (fail || s_ready) begin
        state_d = DONE;
        ready_d = 1'b1;
        err_d = fail;
        rdata_d = fail ? ERR_DATA : s_rdata;
        sticky_d = sticky_q || fail;
      end
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      sel_q <= '0;
      unmap_q <= 1'b0;
      cnt_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      sel_q <= sel_d;
      unmap_q <= unmap_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q <= err_d;
      sticky_q <= sticky_d;
    end
  end
endmodule
